data_ram_pipe: RTL and testbench

DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

---
 rtl/data_ram_pipe_pkg.sv | 13 +
 rtl/data_ram_pipe.sv | 124 ++++++++++++
 tb/tb_data_ram_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_pipe_pkg.sv
// Shared types and default geometry for the pipelined byte-lane data RAM.
package data_ram_pipe_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 1024;

endpackage

// File: rtl/data_ram_pipe.sv
// Single-port data RAM with byte-lane writes, one-cycle registered reads,
// out-of-range error pulses and an optional zero-fill sweep after reset.
module data_ram_pipe
  import data_ram_pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CLR_ON_RST = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ce,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W/8-1:0]   i_sel,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_ready,
  output logic                  o_rvalid,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS   = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int IDX_W = ADDR_W - OFS;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam state_e RST_STATE = (CLR_ON_RST != 0) ? INIT : RUN;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_lo;
  logic              in_range;
  logic              acc;
  logic              mem_we;
  logic [CNT_W-1:0]  mem_waddr;
  logic [LANES-1:0]  mem_wsel;
  logic [DATA_W-1:0] mem_wdata;

  assign idx      = i_addr[ADDR_W-1:OFS];
  assign idx_lo   = idx[CNT_W-1:0];
  assign in_range = (idx < IDX_W'(DEPTH));
  assign o_ready  = (state_q == RUN);
  assign acc      = i_ce & o_ready;

  // Sub-word address bits only select a byte within the word and are ignored.
  generate
    if (OFS > 0) begin : g_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^i_addr[OFS-1:0];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = idx_lo;
    mem_wsel  = i_sel;
    mem_wdata = i_data;
    case (state_q)
      INIT: begin
        // Sweep claims the write port; requests are ignored until RUN.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wsel  = '1;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) state_d = RUN;
      end
      default: begin
        if (acc) begin
          err_d = ~in_range;
          if (i_we) begin
            mem_we = in_range;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = in_range ? mem[idx_lo] : '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage has no reset; only the sweep clears it.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < LANES; k++) begin
        if (mem_wsel[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_err    = err_q;
  assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_data_ram_pipe.sv
// Self-checking bench for data_ram_pipe: scoreboarded responses from a cleared
// 16-word instance plus a no-clear instance for the immediate-ready case.
module tb_data_ram_pipe;

  logic        clk = 1'b0;
  logic        rst_n, ce, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  logic        b_rst_n, b_ce, b_we;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_sel;
  logic        b_ready, b_rvalid, b_err;
  logic [31:0] b_rdata;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  logic [33:0] exp_q[$];
  int          due_q[$];
  logic [31:0] model [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .CLR_ON_RST(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_we(we), .i_addr(addr),
    .i_sel(sel), .i_data(wdata), .o_ready(ready), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_err(err)
  );

  data_ram_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .CLR_ON_RST(0)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_ce(b_ce), .i_we(b_we), .i_addr(b_addr),
    .i_sel(b_sel), .i_data(b_wdata), .o_ready(b_ready), .o_rvalid(b_rvalid),
    .o_rdata(b_rdata), .o_err(b_err)
  );

  // Response monitor: every pulse must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    logic [33:0] e;
    int          d;
    if (rvalid === 1'b1 || err === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_resp: err=%b rvalid=%b rdata=%h cycle=%0d, required no response", err, rvalid, rdata, cyc);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if ({err, rvalid, rdata} !== e || d != cyc)
          $display("FAIL resp: got err=%b rvalid=%b rdata=%h at cycle %0d, required err=%b rvalid=%b rdata=%h at cycle %0d",
                   err, rvalid, rdata, cyc, e[33], e[32], e[31:0], d);
        else pass_cnt++;
      end
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      chk_cnt++;
      e = exp_q.pop_front();
      d = due_q.pop_front();
      $display("FAIL missing_resp: no pulse at cycle %0d, required err=%b rvalid=%b rdata=%h", cyc, e[33], e[32], e[31:0]);
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic ir;
    ir = (a[31:2] < 30'd16);
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
    if (w) begin
      if (ir) begin
        for (int k = 0; k < 4; k++) if (s[k]) model[a[5:2]][8*k +: 8] = d[8*k +: 8];
      end else begin
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        due_q.push_back(cyc + 1);
      end
    end else begin
      exp_q.push_back({~ir, 1'b1, ir ? model[a[5:2]] : 32'h0});
      due_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Counts ready-low cycles after reset release while poking i_ce; bounded to 64.
  task automatic release_and_count(output int n);
    n = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      n++;
      ce = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 31)) << 2; sel = 4'hF; wdata = $urandom;
    end
    ce = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", ready); else pass_cnt++;
    chk_cnt++; if (rvalid !== 1'b0 || err !== 1'b0) $display("FAIL reset_pulses: got rvalid=%b err=%b required 0 0", rvalid, err); else pass_cnt++;
    chk_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 00000000", rdata); else pass_cnt++;
    @(posedge clk); #1;
    release_and_count(n);
    chk_cnt++; if (n != 16) $display("FAIL init_len: got %0d required 16", n); else pass_cnt++;
  endtask

  task automatic test_clear_read();
    access(1'b0, 32'h3C, 4'h0, 32'h0);
    idle(2);
  endtask

  task automatic test_byte_lanes();
    access(1'b1, 32'h08, 4'hF, 32'hAABBCCDD);
    access(1'b1, 32'h08, 4'h5, 32'h11223344);
    access(1'b1, 32'h08, 4'h0, 32'hFFFFFFFF);
    access(1'b0, 32'h08, 4'h0, 32'h0);
    idle(2);
    chk_cnt++; if (model[2] !== 32'hAA22CC44) $display("FAIL lane_model: got %h required aa22cc44", model[2]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    access(1'b1, 32'h10, 4'hF, 32'h12345678);
    access(1'b0, 32'h10, 4'h0, 32'h0);
    access(1'b0, 32'h13, 4'hA, 32'h0);
    idle(3);
    chk_cnt++;
    if (rvalid !== 1'b0 || rdata !== 32'h12345678) $display("FAIL rdata_hold: got rvalid=%b rdata=%h required 0 12345678", rvalid, rdata);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    access(1'b0, 32'h40, 4'hF, 32'h0);
    access(1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
    access(1'b1, 32'h1000_0000, 4'hF, 32'h5A5A5A5A);
    access(1'b0, 32'h00, 4'h0, 32'h0);
    access(1'b0, 32'h7F, 4'h0, 32'h0);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      access(1'($urandom_range(0, 1)), (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), $urandom);
    for (int i = 0; i < 16; i++) access(1'b0, 32'(i) << 2, 4'h0, 32'h0);
    idle(2);
  endtask

  task automatic test_reset_inflight();
    int n;
    ce = 1'b1; we = 1'b0; addr = 32'h08; sel = 4'h0;
    @(posedge clk); #1;
    ce = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++; if (rvalid !== 1'b0 || rdata !== 32'h0) $display("FAIL inflight_cancel: got rvalid=%b rdata=%h required 0 00000000", rvalid, rdata); else pass_cnt++;
    @(posedge clk); #1;
    release_and_count(n);
    chk_cnt++; if (n != 16) $display("FAIL init_len_2: got %0d required 16", n); else pass_cnt++;
  endtask

  task automatic test_init_restart();
    int n;
    access(1'b1, 32'h14, 4'hF, 32'hCAFEBABE);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++; if (ready !== 1'b0) $display("FAIL restart_ready: got %b required 0", ready); else pass_cnt++;
    @(posedge clk); #1;
    release_and_count(n);
    chk_cnt++; if (n != 16) $display("FAIL restart_len: got %0d required 16", n); else pass_cnt++;
    access(1'b0, 32'h14, 4'h0, 32'h0);
    access(1'b0, 32'h3C, 4'h0, 32'h0);
    idle(2);
  endtask

  task automatic test_no_clear();
    b_ce = 1'b0; b_we = 1'b0; b_addr = '0; b_sel = '0; b_wdata = '0;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (b_ready !== 1'b1) $display("FAIL noclr_ready: got %b required 1", b_ready); else pass_cnt++;
    b_ce = 1'b1; b_we = 1'b1; b_addr = 32'h04; b_sel = 4'hF; b_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    b_we = 1'b0; b_wdata = 32'h0;
    @(posedge clk); #1;
    b_ce = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (b_rvalid !== 1'b1 || b_err !== 1'b0 || b_rdata !== 32'hCAFEF00D)
      $display("FAIL noclr_read: got rvalid=%b err=%b rdata=%h required 1 0 cafef00d", b_rvalid, b_err, b_rdata);
    else pass_cnt++;
  endtask

  initial begin
    b_rst_n = 1'b0;
    b_ce = 1'b0; b_we = 1'b0; b_addr = '0; b_sel = '0; b_wdata = '0;
    test_reset();
    test_clear_read();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_inflight();
    test_init_restart();
    test_no_clear();
    idle(3);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d pending responses required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
